imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences loading of a program image into the writable instruction memory of the single-cycle RV32I core.
- Receives a framed byte stream on a valid/ready port and assembles little-endian 32-bit words.
- Issues one write per word into instruction RAM and holds the CPU in reset until a complete, checksum-verified image is loaded.
- Sits between the host link (UART RX byte FIFO) and the instruction-memory write port. It also drives the core's reset.

Parameters:
- ADDR_W, 8: word-address width of instruction RAM; depth = 2^ADDR_W words (256).
- MAGIC, 8'hA5: frame start byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte this cycle.
- skip  input  1  level; in WAIT_MAGIC, release CPU with current imem contents.
- reload  input  1  level; in RUN, return to loading, CPU held.
- imem_we  output  1  instruction RAM write enable (single-cycle pulse).
- imem_waddr  output  ADDR_W  word address.
- imem_wdata  output  32  word data.
- cpu_rst_n  output  1  active-low CPU reset; 0 = CPU held.
- busy  output  1  high in any state except RUN.
- done  output  1  high in RUN.
- err  output  1  sticky frame error.

Behaviour:
- Reset (async, rst_n=0):
  - State = WAIT_MAGIC.
  - cpu_rst_n=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - rx_ready=0 during reset; busy=1, done=0, err=0.
  - Checksum accumulator, byte index and word counter all = 0.
- Handshake: a byte is consumed only when rx_valid && rx_ready at the clk edge. rx_ready is combinational from state:
  - 1 in WAIT_MAGIC, CNT_LO, CNT_HI, DATA, CHECK.
  - 0 in WRITE and RUN.
- Frame format: MAGIC, count low byte, count high byte, then count×4 data bytes (each word least-significant byte first), then checksum = XOR of all data bytes.
- State transitions:
  - WAIT_MAGIC:
    - byte==MAGIC → CNT_LO; clear err, checksum, word counter.
    - Any other byte is dropped and the state is held.
    - skip=1 with no byte consumed → RUN. A consumed byte takes priority over skip.
  - CNT_LO → CNT_HI: latch low byte.
  - CNT_HI: form the 16-bit count.
    - count==0 or count>2^ADDR_W → err=1, WAIT_MAGIC.
    - Otherwise → DATA.
  - DATA:
    - Shift each byte into the word register at lane = byte index; XOR it into the checksum.
    - On the 4th byte → WRITE.
  - WRITE (exactly one cycle): imem_we=1, imem_waddr=word counter, imem_wdata=assembled word.
    - Word counter +1; byte index cleared.
    - If word counter was count−1 → CHECK, else → DATA.
  - CHECK, byte consumed:
    - Equal to checksum → RUN.
    - Not equal → err=1, WAIT_MAGIC, CPU stays held.
  - RUN:
    - cpu_rst_n=1 and done=1, registered; both first high the cycle after the checksum byte is accepted.
    - reload=1 → WAIT_MAGIC; cpu_rst_n=0 and done=0 on the next cycle.
- Outputs in non-WRITE states: imem_we=0; imem_waddr and imem_wdata hold their last values.
- Word addresses start at 0 per frame, increment by one, and never wrap. The count limit guarantees the last address ≤ 2^ADDR_W−1.
- Gaps (rx_valid low) in any state simply stall; there is no timeout.
- err is not cleared by skip; it clears only when the next MAGIC is accepted or on reset.
- Words already written by an aborted frame stay in RAM; the CPU stays held.
- Reset mid-frame aborts immediately to the reset values above; no partial write completes.

Test Plan:
- Two-word load: A5 02 00 | 93 00 10 00 | 63 00 00 00 | E0 → imem_we pulses at addr 0 with 0x00100093 and at addr 1 with 0x00000063; cpu_rst_n=1 and done=1 the cycle after E0; err=0.
- Same frame with checksum E1 → both writes occur, err=1, cpu_rst_n stays 0. A following correct frame clears err and releases the CPU.
- Count 00 00, and count 01 01 with ADDR_W=8 → err=1 after the count-high byte, no imem_we, back in WAIT_MAGIC. Leading bytes 00 FF before A5 are dropped without effect.
- Back-pressure: rx_valid held high continuously through a one-word frame → rx_ready=0 during WRITE, no byte is lost or duplicated. Random rx_valid gaps produce identical writes.
- Full 256-word frame (A5 00 01 …) → 256 writes at addr 0..255, no wrap, RUN. Then reload → cpu_rst_n=0 next cycle and state WAIT_MAGIC.
- skip in WAIT_MAGIC → RUN with no writes. Separately, assert rst_n low after the 6th data byte → all outputs at reset values immediately, no imem_we; a subsequent clean frame loads correctly from addr 0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes little-endian words into
// instruction RAM and holds the CPU in reset until a checksum-verified image is loaded.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              skip,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_WAIT_MAGIC,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_RUN
  } state_e;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [ADDR_W-1:0] cnt_last_q, cnt_last_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q, run_d;

  logic              byte_fire;
  logic              lane_fire;
  logic [16:0]       count_full;
  logic              count_bad;

  assign byte_fire  = rx_valid && rx_ready;
  assign lane_fire  = byte_fire && (state_q == S_DATA);
  assign count_full = {1'b0, rx_data, cnt_lo_q};
  assign count_bad  = (count_full == 17'd0) || (count_full > DEPTH);

  // Each incoming data byte lands in the lane selected by the byte index (LSB first).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_d[8*gi +: 8] = (lane_fire && (byte_idx_q == 2'(gi))) ? rx_data
                                                                     : word_q[8*gi +: 8];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_MAGIC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_MAGIC: begin
        if (byte_fire) begin
          if (rx_data == MAGIC) state_d = S_CNT_LO;
        end else if (skip) begin
          state_d = S_RUN;
        end
      end
      S_CNT_LO: if (byte_fire) state_d = S_CNT_HI;
      S_CNT_HI: if (byte_fire) state_d = count_bad ? S_WAIT_MAGIC : S_DATA;
      S_DATA:   if (byte_fire && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE:  state_d = (word_cnt_q == cnt_last_q) ? S_CHECK : S_DATA;
      S_CHECK:  if (byte_fire) state_d = (rx_data == csum_q) ? S_RUN : S_WAIT_MAGIC;
      S_RUN:    if (reload) state_d = S_WAIT_MAGIC;
      default:  state_d = S_WAIT_MAGIC;
    endcase
  end

  // State-decoded outputs; rx_ready is forced low while reset is asserted.
  always_comb begin
    rx_ready = 1'b0;
    imem_we  = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_WAIT_MAGIC, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: rx_ready = rst_n;
      S_WRITE: imem_we = 1'b1;
      S_RUN:   busy    = 1'b0;
      default: ;
    endcase
  end

  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = run_q;
  assign done       = run_q;
  assign err        = err_q;

  always_comb begin
    cnt_lo_d   = cnt_lo_q;
    cnt_last_d = cnt_last_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    err_d      = err_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_WAIT_MAGIC: begin
        if (byte_fire && (rx_data == MAGIC)) begin
          err_d      = 1'b0;
          csum_d     = 8'd0;
          word_cnt_d = '0;
          byte_idx_d = 2'd0;
        end
      end
      S_CNT_LO: if (byte_fire) cnt_lo_d = rx_data;
      S_CNT_HI: begin
        if (byte_fire) begin
          if (count_bad) err_d = 1'b1;
          else           cnt_last_d = ADDR_W'(count_full - 17'd1);
        end
      end
      S_DATA: begin
        if (byte_fire) begin
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // Present the finished word on the write port during the WRITE cycle.
          if (byte_idx_q == 2'd3) begin
            waddr_d = word_cnt_q;
            wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        byte_idx_d = 2'd0;
      end
      S_CHECK: if (byte_fire && (rx_data != csum_q)) err_d = 1'b1;
      default: ;
    endcase
  end

  assign run_d = (state_d == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo_q   <= 8'd0;
      cnt_last_q <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      csum_q     <= 8'd0;
      err_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      run_q      <= 1'b0;
    end else begin
      cnt_lo_q   <= cnt_lo_d;
      cnt_last_q <= cnt_last_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames are parsed by a queue-based reference model
// and the captured RAM writes and status outputs are compared against it.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  MAGIC  = 8'hA5;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              skip;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .skip      (skip),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_err;
  bit          exp_run;
  bit          in_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("we_in_reset", {31'd0, imem_we}, 32'd0);
    end else if (imem_we) begin
      got_addr.push_back(32'(imem_waddr));
      got_data.push_back(imem_wdata);
      check_val("rdy_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  // Reference: skip to MAGIC, read count, assemble LE words, XOR checksum.
  task automatic model_frame();
    int          i;
    int          count;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_run = 1'b0;
    i = 0;
    while (i < frame_q.size() && frame_q[i] != MAGIC) i++;
    exp_err = 1'b0;
    i++;
    count = int'(frame_q[i]) | (int'(frame_q[i+1]) << 8);
    i += 2;
    if (count == 0 || count > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'd0;
    for (int k = 0; k < count; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w[8*b +: 8] = frame_q[i];
        cs = cs ^ frame_q[i];
        i++;
      end
      exp_addr.push_back(32'(k));
      exp_data.push_back(w);
    end
    exp_run = (frame_q[i] == cs);
    exp_err = !exp_run;
  endtask

  task automatic build_frame(input int count, input bit corrupt, input int njunk);
    logic [7:0] b;
    logic [7:0] cs;
    logic [7:0] flip;
    frame_q.delete();
    repeat (njunk) begin
      b = 8'($urandom);
      if (b == MAGIC) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(MAGIC);
    frame_q.push_back(8'(count));
    frame_q.push_back(8'(count >> 8));
    if (count >= 1 && count <= (1 << ADDR_W)) begin
      cs = 8'd0;
      repeat (count * 4) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        cs = cs ^ b;
      end
      flip = corrupt ? 8'(1 << $urandom_range(7, 0)) : 8'd0;
      frame_q.push_back(cs ^ flip);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    int tries;
    bit acc;
    n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    acc   = 1'b0;
    tries = 0;
    while (!acc) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      acc      = rx_ready;
      @(posedge clk);
      tries++;
      if (!acc && tries > 64) begin
        check_val("rx_timeout", {31'd0, rx_ready}, 32'd1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_val("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check_val("reload_done", {31'd0, done}, 32'd0);
    check_val("reload_busy", {31'd0, busy}, 32'd1);
    check_val("reload_rdy", {31'd0, rx_ready}, 32'd1);
    in_run = 1'b0;
  endtask

  // Sends frame_q, then compares captured writes and status with the model.
  task automatic run_frame(input string name, input int gap_max);
    int n;
    if (in_run) do_reload();
    got_addr.delete();
    got_data.delete();
    model_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], gap_max);
    @(negedge clk);
    rx_valid = 1'b0;
    check_val({name, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int k = 0; k < n; k++) begin
      check_val({name, "_addr"}, got_addr[k], exp_addr[k]);
      check_val({name, "_data"}, got_data[k], exp_data[k]);
    end
    check_val({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_val({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, exp_run});
    check_val({name, "_done"}, {31'd0, done}, {31'd0, exp_run});
    check_val({name, "_busy"}, {31'd0, busy}, {31'd0, !exp_run});
    check_val({name, "_rdy"}, {31'd0, rx_ready}, {31'd0, !exp_run});
    $display("frame %s: %0d bytes, %0d writes, err=%0b run=%0b", name, frame_q.size(),
             got_addr.size(), err, cpu_rst_n);
    in_run = exp_run;
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_rdy"}, {31'd0, rx_ready}, 32'd0);
    check_val({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_val({name, "_we"}, {31'd0, imem_we}, 32'd0);
    check_val({name, "_waddr"}, 32'(imem_waddr), 32'd0);
    check_val({name, "_wdata"}, imem_wdata, 32'd0);
    check_val({name, "_busy"}, {31'd0, busy}, 32'd1);
    check_val({name, "_done"}, {31'd0, done}, 32'd0);
    check_val({name, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    skip     = 1'b0;
    reload   = 1'b0;
    in_run   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two-word load, then the same frame with a bad checksum, then a clean reload.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                8'h63, 8'h00, 8'h00, 8'h00, 8'hE0};
    run_frame("two_word", 0);
    check_val("two_word_w0", got_data[0], 32'h0010_0093);
    check_val("two_word_w1", got_data[1], 32'h0000_0063);
    frame_q[11] = 8'hE1;
    run_frame("bad_csum", 0);
    frame_q[11] = 8'hE0;
    run_frame("recover", 2);

    // Illegal counts, with leading junk dropped.
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    run_frame("count_zero", 1);
    frame_q = '{8'hA5, 8'h01, 8'h01};
    run_frame("count_257", 0);

    // Continuous valid through a one-word frame, then the same bytes with gaps.
    build_frame(1, 1'b0, 0);
    run_frame("backpressure", 0);
    run_frame("gappy", 3);

    // Full-depth image, then reload.
    build_frame(256, 1'b0, 0);
    run_frame("full", 1);
    do_reload();

    // skip releases the CPU but leaves a sticky error in place.
    build_frame(2, 1'b1, 0);
    run_frame("pre_skip", 0);
    got_addr.delete();
    @(negedge clk);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    check_val("skip_done", {31'd0, done}, 32'd1);
    check_val("skip_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check_val("skip_err", {31'd0, err}, 32'd1);
    check_val("skip_nwr", 32'(got_addr.size()), 32'd0);
    $display("skip: done=%0b err=%0b", done, err);
    in_run = 1'b1;

    // Reset after the sixth data byte of a two-word frame.
    do_reload();
    build_frame(2, 1'b0, 0);
    for (int i = 0; i < 9; i++) send_byte(frame_q[i], 0);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1 check_reset_outputs("mid_reset");
    $display("mid-frame reset applied");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    in_run = 1'b0;
    build_frame(3, 1'b0, 0);
    run_frame("after_reset", 1);

    // Randomized frames.
    for (int t = 0; t < 25; t++) begin
      int cnt;
      case ($urandom_range(7, 0))
        0:       cnt = 0;
        1:       cnt = int'($urandom_range(65535, 257));
        default: cnt = int'($urandom_range(12, 1));
      endcase
      build_frame(cnt, ($urandom_range(3, 0) == 0), int'($urandom_range(2, 0)));
      run_frame($sformatf("rand%0d", t), int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
